// File: rtl/sim_run_controller.sv
// sim_run_controller
//   Run-control sequencer in front of the simulator core. Accepts
//   START/RESUME, PAUSE, STEP and ABORT over a valid/ready command port.
//   It gates the core's per-cycle advance, counts enabled cycles against a
//   programmed budget, and drains the network before reporting completion.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      command accepted when cmd_valid & cmd_ready
//   cmd_op         0 START/RESUME, 1 PAUSE, 2 STEP, 3 ABORT
//   cmd_cycles     run budget, sampled on START from IDLE
//   sim_enable     core advances one simulated cycle while high
//   sim_drain      core stops injecting while high
//   sim_quiescent  core has no traffic in flight
//   state          0 IDLE, 1 RUN, 2 PAUSED, 3 DRAIN
//   current_cycle  enabled cycles since the last START
//   done           one-cycle pulse on DRAIN -> IDLE
//   aborted        qualified by done: run ended by ABORT
//   cmd_err        one-cycle registered pulse for an illegal accepted command
module sim_run_controller #(
    parameter int MAX_CYCLE_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [MAX_CYCLE_WIDTH-1:0] cmd_cycles,
    output logic                       sim_enable,
    output logic                       sim_drain,
    input  logic                       sim_quiescent,
    output logic [1:0]                 state,
    output logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
    output logic                       done,
    output logic                       aborted,
    output logic                       cmd_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_PAUSE = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_ABORT = 2'd3;

    localparam logic [MAX_CYCLE_WIDTH-1:0] CYCLE_ONE = 1;
    localparam logic [MAX_CYCLE_WIDTH-1:0] CYCLE_ZERO = '0;

    logic [MAX_CYCLE_WIDTH-1:0] budget;
    logic                       step_r;
    logic                       abort_r;

    logic                       cmd_accept;
    logic [MAX_CYCLE_WIDTH-1:0] cycle_next;
    logic                       budget_hit;

    // A STEP in flight blocks new commands so it always yields exactly one
    // enabled cycle.
    assign cmd_ready  = (state != ST_DRAIN) && !step_r;
    assign sim_enable = (state == ST_RUN) || step_r;
    assign sim_drain  = (state == ST_DRAIN);
    assign cmd_accept = cmd_valid && cmd_ready;

    // Budget never exceeds 2^W-1, so the increment cannot wrap before the
    // run is forced into DRAIN.
    assign cycle_next = current_cycle + CYCLE_ONE;
    assign budget_hit = sim_enable && (cycle_next == budget);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            budget        <= CYCLE_ZERO;
            current_cycle <= CYCLE_ZERO;
            step_r        <= 1'b0;
            abort_r       <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            step_r  <= 1'b0;

            if (sim_enable) begin
                current_cycle <= cycle_next;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        case (cmd_op)
                            OP_START: begin
                                if (cmd_cycles != CYCLE_ZERO) begin
                                    budget        <= cmd_cycles;
                                    current_cycle <= CYCLE_ZERO;
                                    abort_r       <= 1'b0;
                                    state         <= ST_RUN;
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            OP_PAUSE, OP_STEP: cmd_err <= 1'b1;
                            default: ;  // ABORT while idle is harmless
                        endcase
                    end
                end

                ST_RUN: begin
                    // Expiry wins over a same-edge command, which is dropped
                    // silently.
                    if (budget_hit) begin
                        state <= ST_DRAIN;
                    end else if (cmd_accept) begin
                        case (cmd_op)
                            OP_PAUSE: state <= ST_PAUSED;
                            OP_ABORT: begin
                                abort_r <= 1'b1;
                                state   <= ST_DRAIN;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end

                ST_PAUSED: begin
                    if (step_r) begin
                        if (budget_hit) begin
                            state <= ST_DRAIN;
                        end
                    end else if (cmd_accept) begin
                        case (cmd_op)
                            OP_START: state  <= ST_RUN;
                            OP_STEP:  step_r <= 1'b1;
                            OP_ABORT: begin
                                abort_r <= 1'b1;
                                state   <= ST_DRAIN;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end

                ST_DRAIN: begin
                    if (sim_quiescent) begin
                        state   <= ST_IDLE;
                        done    <= 1'b1;
                        aborted <= abort_r;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller
//   Scoreboard bench for sim_run_controller. A stimulus process drives one
//   command per cycle on the falling edge, advances a reference model of the
//   run-control rules and queues the expected post-edge status. A monitor pops
//   and compares after every rising edge.
module tb_sim_run_controller;

    localparam int W = 5;

    logic         clk;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_cycles;
    logic         sim_enable;
    logic         sim_drain;
    logic         sim_quiescent;
    logic [1:0]   state;
    logic [W-1:0] current_cycle;
    logic         done;
    logic         aborted;
    logic         cmd_err;

    sim_run_controller #(.MAX_CYCLE_WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_cycles    (cmd_cycles),
        .sim_enable    (sim_enable),
        .sim_drain     (sim_drain),
        .sim_quiescent (sim_quiescent),
        .state         (state),
        .current_cycle (current_cycle),
        .done          (done),
        .aborted       (aborted),
        .cmd_err       (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   st;
        logic [W-1:0] cc;
        logic         en;
        logic         rdy;
        logic         drn;
        logic         dn;
        logic         ab;
        logic         er;
    } snap_t;

    snap_t sb_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int en_cnt = 0;

    // Reference model: phase 0 idle, 1 running, 2 paused, 3 draining.
    int m_phase, m_cnt, m_budget;
    bit m_step, m_abort;

    // Random stimulus scratch
    bit         r_v, r_q;
    logic [1:0] r_op;
    logic [W-1:0] r_c;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_budget = 0; m_step = 0; m_abort = 0;
    endtask

    // One cycle: drive inputs, predict what the next rising edge produces.
    task automatic tick(input bit v, input logic [1:0] op, input logic [W-1:0] cyc, input bit q);
        bit    rdy, en, acc, hit, dn, er, ab;
        int    nxt;
        snap_t s;
        if (sim_enable) en_cnt++;
        cmd_valid = v; cmd_op = op; cmd_cycles = cyc; sim_quiescent = q;

        rdy = (m_phase != 3) && !m_step;
        en  = (m_phase == 1) || m_step;
        acc = v && rdy;
        nxt = m_cnt + (en ? 1 : 0);
        hit = en && (nxt == m_budget);
        dn = 0; er = 0; ab = 0;
        m_cnt  = nxt;
        m_step = 0;
        if (hit) begin
            m_phase = 3;
        end else if (m_phase == 3) begin
            if (q) begin m_phase = 0; dn = 1; ab = m_abort; end
        end else if (acc) begin
            if (op == 3) begin
                if (m_phase != 0) begin m_abort = 1; m_phase = 3; end
            end else if (m_phase == 0) begin
                if (op == 0 && cyc != 0) begin
                    m_budget = int'(cyc); m_cnt = 0; m_abort = 0; m_phase = 1;
                end else er = 1;
            end else if (m_phase == 1) begin
                if (op == 1) m_phase = 2; else er = 1;
            end else begin
                if (op == 0) m_phase = 1;
                else if (op == 2) m_step = 1;
                else er = 1;
            end
        end

        s.st  = 2'(m_phase);
        s.cc  = W'(m_cnt);
        s.en  = (m_phase == 1) || m_step;
        s.rdy = (m_phase != 3) && !m_step;
        s.drn = (m_phase == 3);
        s.dn  = dn;
        s.ab  = ab;
        s.er  = er;
        sb_q.push_back(s);
        @(negedge clk);
    endtask

    task automatic drain_to_idle(input int bound);
        int n;
        n = 0;
        while (state != 2'd0 && n < bound) begin
            tick(1'b0, 2'd0, '0, 1'b1);
            n++;
        end
        chk("drain_bound_state", int'(state), 0);
    endtask

    // Monitor
    always begin
        snap_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("state",         int'(state),         int'(e.st));
            chk("current_cycle", int'(current_cycle), int'(e.cc));
            chk("sim_enable",    int'(sim_enable),    int'(e.en));
            chk("cmd_ready",     int'(cmd_ready),     int'(e.rdy));
            chk("sim_drain",     int'(sim_drain),     int'(e.drn));
            chk("done",          int'(done),          int'(e.dn));
            chk("cmd_err",       int'(cmd_err),       int'(e.er));
            if (e.dn) chk("aborted", int'(aborted), int'(e.ab));
        end
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_cycles = '0; sim_quiescent = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_state",  int'(state), 0);
        chk("rst_cc",     int'(current_cycle), 0);
        chk("rst_enable", int'(sim_enable), 0);
        chk("rst_ready",  int'(cmd_ready), 1);
        chk("rst_drain",  int'(sim_drain), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_err",    int'(cmd_err), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic run of 3 cycles with the core already quiescent
        en_cnt = 0;
        tick(1'b1, 2'd0, 5'd3, 1'b1);
        repeat (4) tick(1'b0, 2'd0, '0, 1'b1);
        chk("run3_enabled_cycles", en_cnt, 3);
        chk("run3_done", int'(done), 1);
        chk("run3_aborted", int'(aborted), 0);
        chk("run3_cc", int'(current_cycle), 3);
        chk("run3_state", int'(state), 0);

        // Pause, two steps, resume
        tick(1'b1, 2'd0, 5'd10, 1'b1);
        repeat (3) tick(1'b0, 2'd0, '0, 1'b1);
        tick(1'b1, 2'd1, '0, 1'b1);
        chk("pause_cc", int'(current_cycle), 4);
        tick(1'b1, 2'd2, '0, 1'b1);
        chk("step1_ready_low", int'(cmd_ready), 0);
        chk("step1_enable", int'(sim_enable), 1);
        tick(1'b0, 2'd0, '0, 1'b1);
        chk("step1_cc", int'(current_cycle), 5);
        tick(1'b1, 2'd2, '0, 1'b1);
        tick(1'b0, 2'd0, '0, 1'b1);
        chk("step2_cc", int'(current_cycle), 6);
        tick(1'b1, 2'd0, 5'd1, 1'b1);
        drain_to_idle(20);
        chk("resume_final_cc", int'(current_cycle), 10);

        // Abort with a slow drain
        tick(1'b1, 2'd0, 5'd5, 1'b0);
        tick(1'b0, 2'd0, '0, 1'b0);
        tick(1'b1, 2'd3, '0, 1'b0);
        repeat (4) tick(1'b1, 2'd0, 5'd2, 1'b0);
        chk("abort_still_drain", int'(state), 3);
        chk("abort_ready_low", int'(cmd_ready), 0);
        tick(1'b0, 2'd0, '0, 1'b1);
        chk("abort_done", int'(done), 1);
        chk("abort_aborted", int'(aborted), 1);
        chk("abort_cc", int'(current_cycle), 2);

        // Illegal commands
        tick(1'b1, 2'd0, 5'd0, 1'b1);
        chk("err_start0", int'(cmd_err), 1);
        tick(1'b1, 2'd2, '0, 1'b1);
        chk("err_step_idle", int'(cmd_err), 1);
        tick(1'b1, 2'd0, 5'd8, 1'b1);
        tick(1'b1, 2'd1, '0, 1'b1);
        tick(1'b1, 2'd1, '0, 1'b1);
        chk("err_pause_paused", int'(cmd_err), 1);
        chk("err_pause_state", int'(state), 2);
        tick(1'b1, 2'd0, 5'd3, 1'b1);
        tick(1'b1, 2'd0, 5'd3, 1'b1);
        chk("err_start_run", int'(cmd_err), 1);
        chk("err_start_state", int'(state), 1);
        tick(1'b1, 2'd3, '0, 1'b1);
        drain_to_idle(10);

        // Budget expiry on the same edge as PAUSE
        tick(1'b1, 2'd0, 5'd4, 1'b1);
        repeat (3) tick(1'b0, 2'd0, '0, 1'b1);
        tick(1'b1, 2'd1, '0, 1'b0);
        chk("expiry_vs_pause_state", int'(state), 3);
        chk("expiry_vs_pause_err", int'(cmd_err), 0);
        drain_to_idle(10);

        // Full-width budget
        tick(1'b1, 2'd0, 5'd31, 1'b1);
        drain_to_idle(40);
        chk("max_budget_cc", int'(current_cycle), 31);

        // Asynchronous reset mid-run
        tick(1'b1, 2'd0, 5'd5, 1'b1);
        repeat (2) tick(1'b0, 2'd0, '0, 1'b1);
        chk("pre_reset_cc", int'(current_cycle), 2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_state",  int'(state), 0);
        chk("async_rst_cc",     int'(current_cycle), 0);
        chk("async_rst_enable", int'(sim_enable), 0);
        @(negedge clk);
        @(negedge clk);
        chk("async_rst_no_done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_v  = ($urandom_range(0, 2) != 0);
            r_op = 2'($urandom_range(0, 3));
            r_c  = ($urandom_range(0, 9) == 0) ? 5'd31 : W'($urandom_range(0, 6));
            r_q  = ($urandom_range(0, 3) != 0);
            tick(r_v, r_op, r_c, r_q);
        end
        tick(1'b1, 2'd3, '0, 1'b1);
        drain_to_idle(60);

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
